// File: rtl/mem_arbiter_pkg.sv
// Shared constants and FSM encoding for the two-port memory arbiter.
package mem_arbiter_pkg;

    localparam int DEF_WORD_WIDTH = 32;
    localparam int DEF_MEM_NUM    = 105;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr2.sv
// Two-way round-robin picker: on a tie the port that was not granted
// last wins; sel is the index of the granted port.
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt,
    output logic       sel
);

    always_comb begin
        gnt = 2'b00;
        sel = 1'b0;
        unique case (req)
            2'b01: begin
                gnt = 2'b01;
                sel = 1'b0;
            end
            2'b10: begin
                gnt = 2'b10;
                sel = 1'b1;
            end
            2'b11: begin
                gnt = last ? 2'b01 : 2'b10;
                sel = ~last;
            end
            default: begin
                gnt = 2'b00;
                sel = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one word-addressed memory between the
// fetch port (m0) and the load/store port (m1).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int MEM_NUM    = DEF_MEM_NUM
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [WORD_WIDTH-1:0] m0_addr,
    input  logic [WORD_WIDTH-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [WORD_WIDTH-1:0] m0_rdata,
    output logic                  m0_err,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [WORD_WIDTH-1:0] m1_addr,
    input  logic [WORD_WIDTH-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [WORD_WIDTH-1:0] m1_rdata,
    output logic                  m1_err,
    output logic [WORD_WIDTH-1:0] mem_addr,
    output logic                  mem_r,
    output logic                  mem_w,
    output logic [WORD_WIDTH-1:0] mem_wdata,
    input  logic [WORD_WIDTH-1:0] mem_rdata
);

    arb_state_t            state;
    arb_state_t            state_nxt;
    logic                  last;
    logic                  cport;
    logic                  cwe;
    logic [WORD_WIDTH-1:0] caddr;
    logic [WORD_WIDTH-1:0] cwdata;
    logic [1:0]            pick;
    logic                  psel;
    logic                  arb_en;
    logic                  grant;
    logic                  acc;
    logic                  in_range;
    logic [WORD_WIDTH-1:0] rd_word;

    arb_rr2 u_rr (
        .req  ({m1_req, m0_req}),
        .last (last),
        .gnt  (pick),
        .sel  (psel)
    );

    // Gating with rst keeps a reset cycle from granting or touching MEM.
    assign arb_en   = (state != ARB_ACCESS) && !rst;
    assign grant    = arb_en && (pick != 2'b00);
    assign m0_gnt   = arb_en && pick[0];
    assign m1_gnt   = arb_en && pick[1];

    assign acc      = (state == ARB_ACCESS) && !rst;
    assign in_range = caddr < WORD_WIDTH'(MEM_NUM);
    assign rd_word  = in_range ? mem_rdata : '0;

    assign mem_addr  = acc ? caddr : '0;
    assign mem_r     = acc && !cwe && in_range;
    assign mem_w     = acc && cwe && in_range;
    assign mem_wdata = (acc && cwe) ? cwdata : '0;

    always_comb begin
        state_nxt = state;
        unique case (state)
            ARB_IDLE:   state_nxt = grant ? ARB_ACCESS : ARB_IDLE;
            ARB_ACCESS: state_nxt = ARB_RESP;
            ARB_RESP:   state_nxt = grant ? ARB_ACCESS : ARB_IDLE;
            default:    state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last   <= 1'b1;
            cport  <= 1'b0;
            cwe    <= 1'b0;
            caddr  <= '0;
            cwdata <= '0;
        end else if (grant) begin
            last   <= psel;
            cport  <= psel;
            cwe    <= psel ? m1_we : m0_we;
            caddr  <= psel ? m1_addr : m0_addr;
            cwdata <= psel ? m1_wdata : m0_wdata;
        end
    end

    // Only the selected port's response registers move; a write leaves rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            m0_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m0_err    <= 1'b0;
            m1_rvalid <= 1'b0;
            m1_rdata  <= '0;
            m1_err    <= 1'b0;
        end else begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            if (state == ARB_ACCESS) begin
                if (!cport) begin
                    m0_rvalid <= 1'b1;
                    m0_err    <= !in_range;
                    if (!cwe) begin
                        m0_rdata <= rd_word;
                    end
                end else begin
                    m1_rvalid <= 1'b1;
                    m1_err    <= !in_range;
                    if (!cwe) begin
                        m1_rdata <= rd_word;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, scoreboard queue
// and hand-written multi-cycle sequences.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int W = 32;
    localparam int N = 105;

    logic         clk = 1'b0;
    logic         rst;
    logic         m0_req, m0_we, m1_req, m1_we;
    logic [W-1:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic         m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [W-1:0] m0_rdata, m1_rdata;
    logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
    logic         mem_r, mem_w;

    logic [W-1:0] mem [N];
    logic [W-1:0] ref_mem [N];

    typedef struct {
        bit           p;
        bit           we;
        logic [W-1:0] addr;
        logic [W-1:0] wd;
        int           due;
    } sb_t;

    typedef struct {
        bit           p;
        bit           we;
        logic [W-1:0] addr;
        logic [W-1:0] wdata;
        logic [W-1:0] exp_rdata;
        bit           exp_err;
    } vec_t;

    sb_t          q[$];
    vec_t         tbl[8];
    int           checks = 0;
    int           failures = 0;
    int           cyc = 0;
    logic [W-1:0] prev0 = '0;
    logic [W-1:0] prev1 = '0;

    mem_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m0_err    (m0_err),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .m1_err    (m1_err),
        .mem_addr  (mem_addr),
        .mem_r     (mem_r),
        .mem_w     (mem_w),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = (mem_addr < N) ? mem[mem_addr] : '0;

    always @(posedge clk) begin
        if (mem_w && mem_addr < N) mem[mem_addr] <= mem_wdata;
    end

    function automatic void chk(string name, logic [W-1:0] act,
                                logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    task automatic monitor();
        sb_t          e;
        bit           acc_pend = 0;
        bit           acc_we = 0;
        logic [W-1:0] acc_addr = '0;
        logic [W-1:0] acc_wd = '0;
        logic [W-1:0] exp_rd;
        bit           ok;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                q.delete();
                acc_pend = 0;
                prev0 = '0;
                prev1 = '0;
                chk("rst_mem_rw", {30'd0, mem_r, mem_w}, '0);
                continue;
            end
            if (acc_pend) begin
                ok = acc_addr < N;
                chk("acc_mem_r", mem_r, !acc_we && ok);
                chk("acc_mem_w", mem_w, acc_we && ok);
                chk("acc_addr", mem_addr, acc_addr);
                if (acc_we && ok) chk("acc_wdata", mem_wdata, acc_wd);
            end else begin
                chk("idle_mem", {mem_addr[29:0], mem_r, mem_w}, '0);
            end
            acc_pend = 0;
            if (m0_rvalid || m1_rvalid) begin
                chk("dual_rvalid", m0_rvalid & m1_rvalid, 0);
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_rvalid actual=%b%b required=00",
                             m1_rvalid, m0_rvalid);
                end else begin
                    e = q.pop_front();
                    ok = e.addr < N;
                    chk("rsp_port", m1_rvalid, e.p);
                    chk("rsp_cycle", cyc, e.due);
                    if (e.we) begin
                        exp_rd = e.p ? prev1 : prev0;
                        if (ok) ref_mem[e.addr] = e.wd;
                    end else begin
                        exp_rd = ok ? ref_mem[e.addr] : '0;
                        if (e.p) prev1 = exp_rd;
                        else prev0 = exp_rd;
                    end
                    chk("rsp_err", e.p ? m1_err : m0_err, !ok);
                    chk("rsp_rdata", e.p ? m1_rdata : m0_rdata, exp_rd);
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                checks++;
                failures++;
                $display("FAIL rvalid_missing actual=0 required=1 due=%0d",
                         q[0].due);
                void'(q.pop_front());
            end
            if (m0_gnt || m1_gnt) begin
                chk("dual_gnt", m0_gnt & m1_gnt, 0);
                e.p    = m1_gnt;
                e.we   = m1_gnt ? m1_we : m0_we;
                e.addr = m1_gnt ? m1_addr : m0_addr;
                e.wd   = m1_gnt ? m1_wdata : m0_wdata;
                e.due  = cyc + 2;
                q.push_back(e);
                acc_pend = 1;
                acc_we   = e.we;
                acc_addr = e.addr;
                acc_wd   = e.wd;
            end
        end
    endtask

    task automatic drive(bit p, bit req, bit we, logic [W-1:0] a,
                         logic [W-1:0] d);
        if (p) begin
            m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
        end else begin
            m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (q.size() == 0) break;
            @(posedge clk);
        end
        chk("drain", q.size(), 0);
    endtask

    task automatic do_txn(bit p, bit we, logic [W-1:0] a, logic [W-1:0] d);
        bit got = 0;
        @(posedge clk); #1;
        drive(p, 1, we, a, d);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (p ? m1_gnt : m0_gnt) begin
                got = 1;
                break;
            end
        end
        chk("txn_gnt", got, 1);
        @(posedge clk); #1;
        drive(p, 0, 0, '0, '0);
        drain();
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int           hits;
        int           ng;
        int           gp[4];
        int           gc[4];
        int           bad;
        bit           got;
        logic [W-1:0] rv;

        for (int i = 0; i < N; i++) begin
            mem[i]     = W'(i * 3 + 1);
            ref_mem[i] = W'(i * 3 + 1);
        end
        mem[5]     = 32'h0000_00AA;
        ref_mem[5] = 32'h0000_00AA;

        tbl[0] = '{0, 0, 5,   0,            32'h0000_00AA, 0};
        tbl[1] = '{1, 1, 10,  32'hDEADBEEF, 32'h0,         0};
        tbl[2] = '{0, 0, 10,  0,            32'hDEADBEEF, 0};
        tbl[3] = '{0, 0, 105, 0,            32'h0,         1};
        tbl[4] = '{1, 1, 200, 32'h1111_2222, 32'h0,        1};
        tbl[5] = '{1, 0, 104, 0,            32'd313,       0};
        tbl[6] = '{0, 1, 0,   32'h0000_1234, 32'h0,        0};
        tbl[7] = '{1, 0, 0,   0,            32'h0000_1234, 0};

        rst = 1'b1;
        drive(0, 1, 0, 32'd3, '0);
        drive(1, 1, 0, 32'd4, '0);
        fork
            monitor();
        join_none
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", {m1_gnt, m0_gnt}, 0);
        chk("rst_rvalid", {m1_rvalid, m0_rvalid}, 0);
        chk("rst_err", {m1_err, m0_err}, 0);
        chk("rst_rdata0", m0_rdata, 0);
        chk("rst_rdata1", m1_rdata, 0);
        chk("rst_memaddr", mem_addr, 0);
        chk("rst_memwd", mem_wdata, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            do_txn(tbl[i].p, tbl[i].we, tbl[i].addr, tbl[i].wdata);
            rv = tbl[i].p ? m1_rdata : m0_rdata;
            chk($sformatf("vec%0d_rdata", i), rv, tbl[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), tbl[i].p ? m1_err : m0_err,
                tbl[i].exp_err);
        end

        // back-to-back m0 reads: new grant lands in the rvalid cycle
        @(posedge clk); #1;
        drive(0, 1, 0, 32'd7, '0);
        hits = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (m0_rvalid && m0_gnt) hits++;
        end
        chk("b2b_overlap", hits, 3);
        @(posedge clk); #1;
        drive(0, 0, 0, '0, '0);
        drain();

        // reset in the would-be ACCESS cycle of a write
        @(posedge clk); #1;
        drive(1, 1, 1, 32'd20, 32'h55);
        got = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m1_gnt) begin
                got = 1;
                break;
            end
        end
        chk("rstw_gnt", got, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1, 0, 0, '0, '0);
        @(negedge clk);
        chk("rstw_mem_w", mem_w, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 1, 0, 32'd1, '0);
        drive(1, 1, 0, 32'd2, '0);
        ng = 0;
        for (int i = 0; i < 12 && ng < 4; i++) begin
            @(negedge clk);
            chk("rstw_no_rv1", m1_rvalid && i < 2, 0);
            if (m0_gnt || m1_gnt) begin
                gp[ng] = m1_gnt ? 1 : 0;
                gc[ng] = cyc;
                ng++;
            end
        end
        chk("rr_count", ng, 4);
        chk("rr_g0", gp[0], 0);
        chk("rr_g1", gp[1], 1);
        chk("rr_g2", gp[2], 0);
        chk("rr_g3", gp[3], 1);
        chk("rr_gap", (gc[3] - gc[0]), 6);
        @(posedge clk); #1;
        drive(0, 0, 0, '0, '0);
        drive(1, 0, 0, '0, '0);
        drain();
        chk("rstw_word", mem[20], 32'd61);

        bad = 0;
        for (int i = 0; i < N; i++) begin
            if (mem[i] !== ref_mem[i]) bad++;
        end
        chk("mem_image", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester controller in front of the word-addressed MEM array (WORD_WIDTH-bit words, MEM_NUM entries).
- Lets the instruction-fetch port (m0) and the load/store port (m1) share one memory.
- Arbitrates round-robin, sequences each access through a small FSM, and returns registered read data with a one-cycle valid pulse.
- Sits between the core's fetch/LSU and MEM, and drives MEM's address, read-enable, write-enable and write-data inputs.

Parameters:
- WORD_WIDTH, `WORD_WIDTH (32): data and address width.
- MEM_NUM, `MEM_NUM (105): number of valid word addresses (0..MEM_NUM-1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- m0_req  in  1  port-0 request; held with fields stable until m0_gnt.
- m0_we  in  1  port-0 write (1) / read (0).
- m0_addr  in  WORD_WIDTH  port-0 word address.
- m0_wdata  in  WORD_WIDTH  port-0 write data.
- m0_gnt  out  1  port-0 request accepted this cycle (combinational).
- m0_rvalid  out  1  port-0 completion pulse (read data or write ack).
- m0_rdata  out  WORD_WIDTH  port-0 read data, valid with m0_rvalid.
- m0_err  out  1  port-0 address out of range, valid with m0_rvalid.
- m1_*  same set as m0_* for port 1.
- mem_addr  out  WORD_WIDTH  to MEM Addr.
- mem_r  out  1  to MEM read enable.
- mem_w  out  1  to MEM write enable (MEM samples the write on clk rising edge).
- mem_wdata  out  WORD_WIDTH  to MEM write data.
- mem_rdata  in  WORD_WIDTH  from MEM R_data (combinational read).

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, last=1 (so port 0 wins the first tie), all gnt/rvalid/err=0, all rdata=0, mem_r=0, mem_w=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation: rst in any cycle forces the reset values at that edge; a captured access is dropped, and a write that had not yet reached ACCESS is never performed.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: if any req, assert one gnt, capture {port, we, addr, wdata} at the edge, go to ACCESS. If no req, stay in IDLE.
  - ACCESS: drive mem_addr from the captured address. For a read, mem_r=1. For a write, mem_w=1 and mem_wdata=captured data. Capture mem_rdata into the selected port's rdata at the edge, go to RESP.
  - RESP: the selected port's rvalid=1 for exactly this cycle. Arbitrate again as in IDLE: on a grant go to ACCESS, else go to IDLE.
- Latency: gnt in cycle N, memory access in N+1, rvalid in N+2. Peak throughput is one access per 2 cycles.
- Arbitration:
  - A single requester is granted immediately.
  - With both requesting, grant the port != last. last updates to the granted port at the edge.
  - gnt is never asserted in ACCESS, and never to both ports at once.
- Writes: rvalid pulses as the ack. rdata is unchanged on a write.
- Range check: addr >= MEM_NUM makes mem_r=0 and mem_w=0 in ACCESS. The response carries rdata=0 and err=1 with rvalid.
- Non-selected port: its rvalid, err and rdata hold (rvalid=0). rdata keeps its last value until overwritten.
- Outside ACCESS: mem_r=0, mem_w=0, mem_addr=0.
- Request dropped before grant: a req deasserted before gnt is simply not serviced (no error).

Decomposition:
- Shared constants file (defines.v): WORD_WIDTH, MEM_NUM, and FSM encodings ARB_IDLE=2'd0, ARB_ACCESS=2'd1, ARB_RESP=2'd2.
- One sub-module, arb_rr2: combinational 2-way round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: gnt[1:0], sel.
- FSM, capture registers and range check live in mem_arbiter.

Test Plan:
- Reset, then m0 read addr 5 with MEM[5]=32'h0000_00AA -> m0_gnt in cycle 1, mem_r=1 and mem_addr=5 in cycle 2, m0_rvalid=1 with m0_rdata=32'hAA in cycle 3, m1 outputs quiet.
- Both ports request continuously (m0 read 1, m1 read 2) -> grants alternate m0, m1, m0, m1 in cycles 1, 3, 5, 7; rvalid alternates in cycles 3, 5, 7, 9; never a double gnt.
- m1 write addr 10 data 32'hDEADBEEF, then m0 read addr 10 -> mem_w=1 for exactly one cycle, m1_rvalid ack with m1_err=0, m0_rdata=32'hDEADBEEF.
- m0 read addr 105 (=MEM_NUM), then m1 write addr 200 -> mem_r=0 and mem_w=0 during both ACCESS cycles; m0_rvalid=1 with m0_err=1 and m0_rdata=0; m1_err=1; no MEM word changes.
- m1 write granted, rst=1 in the following cycle (the would-be ACCESS) -> mem_w stays 0, no m1_rvalid, target word unchanged; after release both ports requesting -> m0 granted first.
- Back-to-back m0 reads held through RESP -> new m0_gnt is asserted in the same cycle as the previous m0_rvalid; no idle cycle between accesses.
